// File: rtl/axil_mmio_master.sv
// axil_mmio_master
// ----------------
// AXI4-Lite initiator for single-beat MMIO reads and writes. On-FPGA logic
// issues one command at a time on a valid/ready command port and receives
// exactly one response on a valid/ready response port. A read or write that
// never gets its B/R beat is completed with a synthesized response after
// TIMEOUT_CYCLES. The late beat, if it ever arrives, is absorbed before the
// next command is accepted.
//
// Ports
//   m_axi_aclk, m_axi_aresetn : clock, asynchronous active-low reset
//   cmd_*   : command in (write flag, address, write data, strobes)
//   rsp_*   : response out (read data, AXI resp code or 2'b11, timeout flag)
//   err_count : saturating count of delivered non-OKAY responses
//   m_axi_* : AXI4-Lite master channels AW, W, B, AR, R (prot tied to 0)
module axil_mmio_master #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                    m_axi_aclk,
  input  logic                    m_axi_aresetn,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]              rsp_resp,
  output logic                    rsp_timeout,
  output logic [15:0]             err_count,
  output logic                    m_axi_awvalid,
  input  logic                    m_axi_awready,
  output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [2:0]              m_axi_awprot,
  output logic                    m_axi_wvalid,
  input  logic                    m_axi_wready,
  output logic [DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
  input  logic                    m_axi_bvalid,
  output logic                    m_axi_bready,
  input  logic [1:0]              m_axi_bresp,
  output logic                    m_axi_arvalid,
  input  logic                    m_axi_arready,
  output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic [2:0]              m_axi_arprot,
  input  logic                    m_axi_rvalid,
  output logic                    m_axi_rready,
  input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic [1:0]              m_axi_rresp
);

  // Counter wide enough to hold TIMEOUT_CYCLES itself.
  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);
  localparam bit TMO_EN = (TIMEOUT_CYCLES != 0);

  typedef enum logic [2:0] {
    IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP, DRAIN_B, DRAIN_R
  } state_e;

  state_e                  state_q, state_d;
  logic                    awvalid_q, awvalid_d;
  logic                    wvalid_q, wvalid_d;
  logic                    arvalid_q, arvalid_d;
  logic                    bready_q, bready_d;
  logic                    rready_q, rready_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic                    write_q, write_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [DATA_WIDTH/8-1:0] wstrb_q, wstrb_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic [1:0]              resp_q, resp_d;
  logic                    timed_out_q, timed_out_d;
  logic [15:0]             err_count_q, err_count_d;
  logic [CNT_W-1:0]        tmo_cnt_q, tmo_cnt_d;
  logic                    timeout_hit;

  assign timeout_hit = TMO_EN && (tmo_cnt_q == CNT_LIMIT);

  // Next-state and registered-output logic. The timeout counter is held at
  // zero outside the response-wait states, so it always starts from zero on
  // entry. A real B/R beat takes priority over an expiring timeout.
  always_comb begin
    state_d     = state_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    arvalid_d   = arvalid_q;
    bready_d    = bready_q;
    rready_d    = rready_q;
    rsp_valid_d = rsp_valid_q;
    write_d     = write_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    rdata_d     = rdata_q;
    resp_d      = resp_q;
    timed_out_d = timed_out_q;
    err_count_d = err_count_q;
    tmo_cnt_d   = '0;

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          write_d = cmd_write;
          addr_d  = cmd_addr;
          wdata_d = cmd_wdata;
          wstrb_d = cmd_wstrb;
          if (cmd_write) begin
            state_d   = WR_REQ;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end else begin
            state_d   = RD_REQ;
            arvalid_d = 1'b1;
          end
        end
      end

      // AW and W retire independently; leave once neither is outstanding.
      WR_REQ: begin
        if (awvalid_q && m_axi_awready) awvalid_d = 1'b0;
        if (wvalid_q && m_axi_wready)   wvalid_d  = 1'b0;
        if (!awvalid_d && !wvalid_d) begin
          state_d  = WR_RESP;
          bready_d = 1'b1;
        end
      end

      RD_REQ: begin
        if (arvalid_q && m_axi_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RD_RESP;
        end
      end

      WR_RESP: begin
        tmo_cnt_d = tmo_cnt_q + 1'b1;
        if (bready_q && m_axi_bvalid) begin
          bready_d    = 1'b0;
          rdata_d     = '0;
          resp_d      = m_axi_bresp;
          timed_out_d = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = RSP;
        end else if (timeout_hit) begin
          bready_d    = 1'b0;
          rdata_d     = '0;
          resp_d      = 2'b11;
          timed_out_d = 1'b1;
          rsp_valid_d = 1'b1;
          state_d     = RSP;
        end
      end

      RD_RESP: begin
        tmo_cnt_d = tmo_cnt_q + 1'b1;
        if (rready_q && m_axi_rvalid) begin
          rready_d    = 1'b0;
          rdata_d     = m_axi_rdata;
          resp_d      = m_axi_rresp;
          timed_out_d = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = RSP;
        end else if (timeout_hit) begin
          rready_d    = 1'b0;
          rdata_d     = '0;
          resp_d      = 2'b11;
          timed_out_d = 1'b1;
          rsp_valid_d = 1'b1;
          state_d     = RSP;
        end
      end

      // Errors are counted when the response is actually handed over.
      // After a timeout the slave may still owe us a beat, so drain it.
      RSP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          if (resp_q != 2'b00 && err_count_q != 16'hFFFF)
            err_count_d = err_count_q + 16'd1;
          if (timed_out_q) begin
            state_d  = write_q ? DRAIN_B : DRAIN_R;
            bready_d = write_q;
            rready_d = !write_q;
          end else begin
            state_d = IDLE;
          end
        end
      end

      DRAIN_B: begin
        if (bready_q && m_axi_bvalid) begin
          bready_d = 1'b0;
          state_d  = IDLE;
        end
      end

      DRAIN_R: begin
        if (rready_q && m_axi_rvalid) begin
          rready_d = 1'b0;
          state_d  = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
    if (!m_axi_aresetn) begin
      state_q     <= IDLE;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      bready_q    <= 1'b0;
      rready_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      write_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      rdata_q     <= '0;
      resp_q      <= 2'b00;
      timed_out_q <= 1'b0;
      err_count_q <= 16'd0;
      tmo_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      arvalid_q   <= arvalid_d;
      bready_q    <= bready_d;
      rready_q    <= rready_d;
      rsp_valid_q <= rsp_valid_d;
      write_q     <= write_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      rdata_q     <= rdata_d;
      resp_q      <= resp_d;
      timed_out_q <= timed_out_d;
      err_count_q <= err_count_d;
      tmo_cnt_q   <= tmo_cnt_d;
    end
  end

  assign cmd_ready     = (state_q == IDLE);
  assign rsp_valid     = rsp_valid_q;
  assign rsp_rdata     = rdata_q;
  assign rsp_resp      = resp_q;
  assign rsp_timeout   = timed_out_q;
  assign err_count     = err_count_q;
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_awaddr  = addr_q;
  assign m_axi_awprot  = 3'b000;
  assign m_axi_wvalid  = wvalid_q;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_wstrb   = wstrb_q;
  assign m_axi_bready  = bready_q;
  assign m_axi_arvalid = arvalid_q;
  assign m_axi_araddr  = addr_q;
  assign m_axi_arprot  = 3'b000;
  assign m_axi_rready  = rready_q;

endmodule

// File: doc/axil_mmio_master.md
# axil_mmio_master

AXI4-Lite initiator that turns a simple command/response handshake into single-beat MMIO reads and writes toward the FireSim control port, the same AXI4-Lite slave interface the host XDMA path drives. It lets on-FPGA logic (bring-up sequencers, debug-bridge hooks, self-test) program simulator MMIO registers in the FireSim clock domain without the host. It has one outstanding transaction, a response timeout, a drain path for late responses, and an error counter.

## Interface
- ADDR_WIDTH, 32, AXI4-Lite address width
- DATA_WIDTH, 32, data width; strobe width is DATA_WIDTH/8
- TIMEOUT_CYCLES, 1024, response-wait limit in cycles; 0 disables the timeout
- m_axi_aclk  input  1  clock
- m_axi_aresetn  input  1  asynchronous active-low reset
- cmd_valid / cmd_ready  input / output  1 / 1  command handshake
- cmd_write  input  1  1 = write, 0 = read
- cmd_addr  input  ADDR_WIDTH  target address
- cmd_wdata / cmd_wstrb  input  DATA_WIDTH / DATA_WIDTH/8  write data and strobes
- rsp_valid / rsp_ready  output / input  1 / 1  response handshake
- rsp_rdata  output  DATA_WIDTH  read data; 0 for writes and timeouts
- rsp_resp  output  2  AXI response code, or 2'b11 on timeout
- rsp_timeout  output  1  response was synthesized by the timeout
- err_count  output  16  saturating count of non-OKAY responses, including timeouts
- m_axi_aw{valid,ready,addr,prot}, m_axi_w{valid,ready,data,strb}, m_axi_b{valid,ready,resp}, m_axi_ar{valid,ready,addr,prot}, m_axi_r{valid,ready,data,resp}: standard AXI4-Lite master channels; awprot and arprot are tied to 3'b000

## Operation
- States: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP, DRAIN_B, DRAIN_R.
- IDLE: cmd_ready=1.
  - A write command is accepted into WR_REQ; a read command into RD_REQ.
  - Address, data and strobe are registered on acceptance.
- WR_REQ:
  - awvalid and wvalid rise together and each drops independently on its own handshake.
  - Go to WR_RESP once both AW and W are accepted, whether in the same cycle or different cycles.
- RD_REQ: arvalid high until arready, then go to RD_RESP.
- There is no timeout in WR_REQ or RD_REQ. An AXI valid, once raised, is never withdrawn.
- WR_RESP: bready=1.
  - On a B handshake, capture bresp and rdata=0, then go to RSP.
- RD_RESP: rready=1.
  - On an R handshake, capture rdata and rresp, then go to RSP.
- Timeout in WR_RESP or RD_RESP:
  - A cycle counter is cleared on entry to the state and increments each cycle.
  - When it reaches TIMEOUT_CYCLES with no handshake, capture resp=2'b11, rdata=0, set timed_out, and go to RSP.
- RSP: rsp_valid held with stable payload until rsp_ready. Then:
  - IDLE if timed_out=0;
  - DRAIN_B or DRAIN_R (matching the command type) if timed_out=1.
- DRAIN_B / DRAIN_R:
  - bready or rready = 1 and cmd_ready=0.
  - The late B or R beat is discarded and not counted. Then go to IDLE.
- err_count increments once per response delivered with rsp_resp != 0, and saturates at 16'hFFFF.
- Reset (at any point, including mid-transaction):
  - state returns to IDLE and all valids and readies drop;
  - rsp payload, err_count and the timeout counter return to 0.
  - Recovering the slave after a mid-transaction reset is the system's responsibility.

## Timing
- Every AXI valid/ready output and rsp_valid is registered. cmd_ready is decoded from the registered state.
- Reset values:
  - cmd_ready=1; rsp_valid=0; all m_axi valids and readies = 0;
  - rsp_rdata, rsp_resp, rsp_timeout and err_count = 0.
- Write path: cmd handshake in cycle 0 → awvalid/wvalid high in cycle 1 → earliest bvalid in cycle 2 → rsp_valid in cycle 3.
- Read path: cmd handshake in cycle 0 → arvalid in cycle 1 → earliest rvalid in cycle 2 → rsp_valid in cycle 3.
- Minimum back-to-back throughput: a new cmd can be accepted the cycle after the rsp handshake (cycle 4), so at most one transaction per 4 cycles.
- A B/R handshake in the same cycle the counter reaches TIMEOUT_CYCLES counts as a real response; the timeout is not taken.
- Timeout response: rsp_valid asserts TIMEOUT_CYCLES+1 cycles after entry to WR_RESP or RD_RESP.
- While rsp_valid=1 and rsp_ready=0, every rsp field and err_count hold.

## Test plan
- Write 0xDEADBEEF, strb 0xF, to 0x100; slave responds in zero-wait fashion → AW/W both valid in cycle 1, rsp_valid in cycle 3 with resp=0, rdata=0, err_count=0.
- Write where the slave accepts W 3 cycles before AW → W beat sent once, wvalid low after its handshake, single B, resp=0.
- Read 0x200; slave returns 0x12345678 with SLVERR after 5 wait cycles → rsp_rdata=0x12345678, rsp_resp=2'b10, err_count=1.
- TIMEOUT_CYCLES=16; read whose R never arrives → rsp_valid 17 cycles after entering RD_RESP, resp=2'b11, rsp_timeout=1. Later R beat → absorbed in DRAIN_R; cmd_ready returns only after it.
- rvalid arrives on exactly the expiry cycle → real data returned, rsp_timeout=0.
- Assert m_axi_aresetn low mid-WR_REQ with rsp_ready held low → outputs reach reset values immediately; after release, cmd_ready=1 and a new read completes normally.
